// File: rtl/timer_pkg.sv
// ----------------------------------------------------------------------------
// timer_pkg
//   Shared types, constants and helpers for the MM:SS timer controller.
//   Contents:
//     state_t    - controller state (IDLE, RUN, PAUSE, DONE), 2-bit encoding
//     DIG_MAX    - largest BCD digit value (9)
//     STENS_MAX  - largest tens-of-seconds digit (5)
//     MMSS_MAX   - largest displayable value, 99:59
//     BCD_ZERO   - 00:00
//     dig_clamp  - saturate one BCD digit to a limit
//     bcd_clamp  - saturate a packed {m_tens,m_ones,s_tens,s_ones} value
// ----------------------------------------------------------------------------
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [3:0]  DIG_MAX   = 4'd9;
    localparam logic [3:0]  STENS_MAX = 4'd5;
    localparam logic [15:0] MMSS_MAX  = 16'h9959;
    localparam logic [15:0] BCD_ZERO  = 16'h0000;

    function automatic logic [3:0] dig_clamp(input logic [3:0] dig,
                                             input logic [3:0] lim);
        return (dig > lim) ? lim : dig;
    endfunction

    // Any digit above 9 becomes 9; tens-of-seconds above 5 becomes 5.
    function automatic logic [15:0] bcd_clamp(input logic [15:0] val);
        return {dig_clamp(val[15:12], DIG_MAX),
                dig_clamp(val[11:8],  DIG_MAX),
                dig_clamp(val[7:4],   STENS_MAX),
                dig_clamp(val[3:0],   DIG_MAX)};
    endfunction

endpackage

// File: rtl/tick_gen.sv
// ----------------------------------------------------------------------------
// tick_gen
//   Prescaler producing a one-cycle tick every TICK_DIV enabled clk cycles.
//   The count runs 0..TICK_DIV-1 while en=1, holds while en=0, and is forced
//   to zero by clr. tick is asserted combinationally in the enabled cycle in
//   which the count sits at TICK_DIV-1; the count then wraps to 0.
//   Ports:
//     clk    in  1  system clock
//     rst_n  in  1  synchronous active-low reset
//     en     in  1  advance the count this cycle
//     clr    in  1  force the count to zero (overrides en)
//     tick   out 1  terminal-count pulse
// ----------------------------------------------------------------------------
module tick_gen #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = en && (cnt == CNT_LAST) && !clr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            if (cnt == CNT_LAST) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/timer_ctrl.sv
// ----------------------------------------------------------------------------
// timer_ctrl
//   Sequencing controller for the MM:SS stopwatch / countdown timer. Owns the
//   run/pause/clear/alarm state, derives a 1 s tick through tick_gen, and keeps
//   the 4-digit BCD value feeding the 7-segment multiplexer.
//   Ports:
//     clk        in   1   system clock
//     rst_n      in   1   synchronous active-low reset
//     btn_start  in   1   pulse: start / pause / resume
//     btn_clear  in   1   pulse: back to IDLE with 00:00
//     mode_down  in   1   0 = count up, 1 = count down (taken on IDLE->RUN)
//     load       in   1   pulse: preset from load_val (IDLE/PAUSE only)
//     load_val   in   16  BCD preset {m_tens,m_ones,s_tens,s_ones}
//     second     out  16  BCD display value, same packing as load_val
//     running    out  1   registered, 1 while in RUN
//     alarm      out  1   registered, 1 while in DONE
//
//   state | meaning
//   ------+-----------------------------------------------------------------
//   IDLE  | stopped, prescaler zero; load accepted; start begins a run
//   RUN   | prescaler counting, value steps once per tick
//   PAUSE | prescaler and value held; load accepted; start resumes
//   DONE  | terminal value reached, alarm on; only clear/reset leave
//
//   Same-cycle priority: rst_n > btn_clear > load > btn_start > tick.
// ----------------------------------------------------------------------------
module timer_ctrl
    import timer_pkg::*;
#(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        btn_start,
    input  logic        btn_clear,
    input  logic        mode_down,
    input  logic        load,
    input  logic [15:0] load_val,
    output logic [15:0] second,
    output logic        running,
    output logic        alarm
);

    state_t      state;
    state_t      state_nxt;
    logic [15:0] second_nxt;
    logic        dir;
    logic        dir_nxt;
    logic        running_nxt;
    logic        alarm_nxt;

    logic        pre_en;
    logic        pre_clr;
    logic        tick;

    // A start pulse in RUN pauses before the prescaler advances, so a tick
    // landing on the same cycle is dropped and the count stays at its last
    // value; the first enabled cycle after resume then ticks immediately.
    assign pre_en  = (state == RUN) && !btn_clear && !btn_start;
    assign pre_clr = btn_clear || (state == IDLE) || (state == DONE);

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (pre_en),
        .clr   (pre_clr),
        .tick  (tick)
    );

    function automatic logic [15:0] bcd_inc(input logic [15:0] val);
        logic [3:0] m_tens;
        logic [3:0] m_ones;
        logic [3:0] s_tens;
        logic [3:0] s_ones;
        {m_tens, m_ones, s_tens, s_ones} = val;
        if (s_ones != DIG_MAX) begin
            s_ones = s_ones + 4'd1;
        end else begin
            s_ones = 4'd0;
            if (s_tens != STENS_MAX) begin
                s_tens = s_tens + 4'd1;
            end else begin
                s_tens = 4'd0;
                if (m_ones != DIG_MAX) begin
                    m_ones = m_ones + 4'd1;
                end else begin
                    m_ones = 4'd0;
                    m_tens = m_tens + 4'd1;
                end
            end
        end
        return {m_tens, m_ones, s_tens, s_ones};
    endfunction

    // Caller guarantees val != 00:00, so the borrow chain always stops.
    function automatic logic [15:0] bcd_dec(input logic [15:0] val);
        logic [3:0] m_tens;
        logic [3:0] m_ones;
        logic [3:0] s_tens;
        logic [3:0] s_ones;
        {m_tens, m_ones, s_tens, s_ones} = val;
        if (s_ones != 4'd0) begin
            s_ones = s_ones - 4'd1;
        end else begin
            s_ones = DIG_MAX;
            if (s_tens != 4'd0) begin
                s_tens = s_tens - 4'd1;
            end else begin
                s_tens = STENS_MAX;
                if (m_ones != 4'd0) begin
                    m_ones = m_ones - 4'd1;
                end else begin
                    m_ones = DIG_MAX;
                    m_tens = m_tens - 4'd1;
                end
            end
        end
        return {m_tens, m_ones, s_tens, s_ones};
    endfunction

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            second  <= BCD_ZERO;
            dir     <= 1'b0;
            running <= 1'b0;
            alarm   <= 1'b0;
        end else begin
            state   <= state_nxt;
            second  <= second_nxt;
            dir     <= dir_nxt;
            running <= running_nxt;
            alarm   <= alarm_nxt;
        end
    end

    // Next state, value and direction.
    always_comb begin
        state_nxt  = state;
        second_nxt = second;
        dir_nxt    = dir;
        if (btn_clear) begin
            state_nxt  = IDLE;
            second_nxt = BCD_ZERO;
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        second_nxt = bcd_clamp(load_val);
                    end else if (btn_start && !(mode_down && (second == BCD_ZERO))) begin
                        state_nxt = RUN;
                        dir_nxt   = mode_down;
                    end
                end
                RUN: begin
                    if (btn_start) begin
                        state_nxt = PAUSE;
                    end else if (tick) begin
                        if (!dir) begin
                            if (second == MMSS_MAX) begin
                                state_nxt = DONE;
                            end else begin
                                second_nxt = bcd_inc(second);
                            end
                        end else begin
                            if (second == BCD_ZERO) begin
                                state_nxt = DONE;
                            end else begin
                                second_nxt = bcd_dec(second);
                                if (bcd_dec(second) == BCD_ZERO) begin
                                    state_nxt = DONE;
                                end
                            end
                        end
                    end
                end
                PAUSE: begin
                    if (load) begin
                        second_nxt = bcd_clamp(load_val);
                    end else if (btn_start) begin
                        state_nxt = RUN;
                    end
                end
                DONE: begin
                    state_nxt = DONE;
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    // Status flags follow the next state so they change on the same edge.
    always_comb begin
        running_nxt = (state_nxt == RUN);
        alarm_nxt   = (state_nxt == DONE);
    end

endmodule

// File: tb/tb_timer_ctrl.sv
module tb_timer_ctrl;

    localparam int TD      = 4;
    localparam int MAX_TOT = 99 * 60 + 59;
    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_DONE  = 3;

    logic        clk;
    logic        rst_n;
    logic        btn_start;
    logic        btn_clear;
    logic        mode_down;
    logic        load;
    logic [15:0] load_val;
    logic [15:0] second;
    logic        running;
    logic        alarm;

    timer_ctrl #(.TICK_DIV(TD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_start (btn_start),
        .btn_clear (btn_clear),
        .mode_down (mode_down),
        .load      (load),
        .load_val  (load_val),
        .second    (second),
        .running   (running),
        .alarm     (alarm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [15:0] sec;
        logic        run;
        logic        alm;
    } exp_t;

    exp_t sb[$];
    int   cyc_cnt  = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    // reference model: elapsed time kept as whole seconds
    int m_st  = M_IDLE;
    int m_tot = 0;
    int m_ph  = 0;
    bit m_dir = 1'b0;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int t);
        int mm;
        int ss;
        mm = t / 60;
        ss = t % 60;
        return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
    endfunction

    function automatic int load_total(input logic [15:0] lv);
        int mt;
        int mo;
        int st;
        int so;
        mt = (lv[15:12] > 9) ? 9 : int'(lv[15:12]);
        mo = (lv[11:8]  > 9) ? 9 : int'(lv[11:8]);
        st = (lv[7:4]   > 5) ? 5 : int'(lv[7:4]);
        so = (lv[3:0]   > 9) ? 9 : int'(lv[3:0]);
        return (mt * 10 + mo) * 60 + st * 10 + so;
    endfunction

    task automatic one_second();
        if (!m_dir) begin
            if (m_tot == MAX_TOT) m_st = M_DONE;
            else m_tot++;
        end else begin
            if (m_tot > 0) m_tot--;
            if (m_tot == 0) m_st = M_DONE;
        end
    endtask

    task automatic model_edge(input bit rn, input bit sta, input bit cl, input bit ld,
                              input logic [15:0] lv, input bit md);
        if (!rn) begin
            m_st = M_IDLE; m_tot = 0; m_ph = 0; m_dir = 1'b0;
        end else if (cl) begin
            m_st = M_IDLE; m_tot = 0; m_ph = 0;
        end else begin
            case (m_st)
                M_IDLE: begin
                    if (ld) m_tot = load_total(lv);
                    else if (sta && !(md && m_tot == 0)) begin
                        m_st = M_RUN; m_ph = 0; m_dir = md;
                    end
                end
                M_PAUSE: begin
                    if (ld) m_tot = load_total(lv);
                    else if (sta) m_st = M_RUN;
                end
                M_RUN: begin
                    if (sta) m_st = M_PAUSE;
                    else if (m_ph < TD - 1) m_ph++;
                    else begin
                        m_ph = 0;
                        one_second();
                    end
                end
                default: ;
            endcase
        end
    endtask

    // one clock edge: apply inputs, predict the result, wait past the edge
    task automatic drive(input bit rn, input bit sta, input bit cl, input bit ld,
                         input logic [15:0] lv, input bit md);
        exp_t e;
        rst_n = rn; btn_start = sta; btn_clear = cl; load = ld; load_val = lv; mode_down = md;
        model_edge(rn, sta, cl, ld, lv, md);
        e.cyc = cyc_cnt + 1;
        e.sec = to_bcd(m_tot);
        e.run = (m_st == M_RUN);
        e.alm = (m_st == M_DONE);
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input bit md);
        for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, md);
    endtask

    task automatic start(input bit md);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, md);
    endtask

    task automatic clear();
        drive(1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0);
    endtask

    task automatic do_load(input logic [15:0] lv);
        drive(1'b1, 1'b0, 1'b0, 1'b1, lv, 1'b0);
    endtask

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc == cyc_cnt) begin
            exp_t e;
            e = sb.pop_front();
            chk("sb_second",  32'(second),  32'(e.sec));
            chk("sb_running", 32'(running), 32'(e.run));
            chk("sb_alarm",   32'(alarm),   32'(e.alm));
        end
    end

    initial begin
        rst_n = 1'b0; btn_start = 1'b0; btn_clear = 1'b0;
        mode_down = 1'b0; load = 1'b0; load_val = 16'h0000;
        @(posedge clk);
        #1;

        // reset held with start pulsing
        for (int i = 0; i < 4; i++) drive(1'b0, i[0], 1'b0, 1'b0, 16'h0000, 1'b0);
        chk("rst_second",  32'(second),  32'h0);
        chk("rst_running", 32'(running), 32'h0);
        chk("rst_alarm",   32'(alarm),   32'h0);

        // up count 61 s
        start(1'b0);
        idle(4 * 61, 1'b0);
        chk("up_second",  32'(second),  32'h0101);
        chk("up_running", 32'(running), 32'h1);
        clear();

        // carry into terminal value and DONE
        do_load(16'h9958);
        start(1'b0);
        idle(4, 1'b0);
        chk("term_9959", 32'(second), 32'h9959);
        idle(4, 1'b0);
        chk("term_alarm",  32'(alarm),  32'h1);
        chk("term_hold",   32'(second), 32'h9959);
        for (int i = 0; i < 3; i++) start(1'b0);
        chk("done_start_ignored", 32'(alarm), 32'h1);
        clear();
        chk("clr_second", 32'(second), 32'h0);
        chk("clr_alarm",  32'(alarm),  32'h0);

        // countdown
        do_load(16'h0100);
        start(1'b1);
        idle(4, 1'b1);
        chk("down_0059", 32'(second), 32'h0059);
        idle(4 * 59, 1'b1);
        chk("down_zero",  32'(second), 32'h0);
        chk("down_alarm", 32'(alarm),  32'h1);
        clear();
        start(1'b1);
        chk("down_zero_start_ignored", 32'(running), 32'h0);

        // pause / resume
        start(1'b0);
        idle(2, 1'b0);
        start(1'b0);
        idle(20, 1'b0);
        chk("pause_hold",    32'(second),  32'h0);
        chk("pause_running", 32'(running), 32'h0);
        start(1'b0);
        idle(1, 1'b0);
        chk("resume_no_tick_yet", 32'(second), 32'h0);
        idle(1, 1'b0);
        chk("resume_tick", 32'(second), 32'h0001);
        do_load(16'h1234);
        chk("load_in_run_ignored", 32'(second), 32'h0001);
        start(1'b0);
        do_load(16'h7A6F);
        chk("load_clamp", 32'(second), 32'h7959);

        // priority
        clear();
        start(1'b0);
        idle(5, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 1'b1, 16'h1234, 1'b0);
        chk("prio_second",  32'(second),  32'h0);
        chk("prio_running", 32'(running), 32'h0);
        start(1'b0);
        idle(6, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
        chk("rst_mid_second",  32'(second),  32'h0);
        chk("rst_mid_running", 32'(running), 32'h0);

        // pause coinciding with a tick
        start(1'b0);
        idle(3, 1'b0);
        start(1'b0);
        chk("collide_no_tick", 32'(second), 32'h0);
        start(1'b0);
        idle(1, 1'b0);
        chk("collide_resume_tick", 32'(second), 32'h0001);
        clear();

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            bit rn;
            bit sta;
            bit cl;
            bit ld;
            bit md;
            logic [15:0] lv;
            rn  = ($urandom_range(0, 499) != 0);
            sta = ($urandom_range(0, 7) == 0);
            cl  = ($urandom_range(0, 79) == 0);
            ld  = ($urandom_range(0, 24) == 0);
            md  = 1'($urandom_range(0, 1));
            lv  = 16'($urandom);
            drive(rn, sta, cl, ld, lv, md);
        end

        idle(2, 1'b0);
        @(negedge clk);
        #1;
        chk("sb_drained", 32'(sb.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
